// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared audio types and frame-timing constants for the sample-stream
//   blocks (src_* sources, the I2S transmitter and future receivers).
//   Contents:
//     sample_t       signed 16-bit channel sample (two's complement)
//     stereo_t       packed {l, r} sample pair
//     I2S_SLOT_BITS  BCLK periods per channel slot
//     I2S_MCLK_DIV   mclk cycles per BCLK period
//     MCLK_PER_FS    mclk cycles per sample frame
//     frame_len()    mclk cycles per stereo frame for a given slot/divider
package audio_pkg;

  typedef shortint sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_MCLK_DIV  = 4;
  localparam int MCLK_PER_FS   = 256;

  // One frame is a left slot plus a right slot, each SLOT_BITS bit clocks
  // long, and each bit clock spans MCLK_DIV master clocks.
  function automatic int frame_len(input int slot_bits, input int mclk_div);
    return 2 * slot_bits * mclk_div;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen
//   Free-running I2S frame counter and the timing fields decoded from it.
//   Kept separate so a receiver can share the exact same frame timing.
//   Ports:
//     mclk         in   master clock
//     rst          in   synchronous active-high reset (counter to 0)
//     bclk_phase   out  bit-clock level for the current count
//     slot_bit     out  bit position inside the current channel slot
//     channel      out  0 = left slot, 1 = right slot
//     frame_first  out  count is 0 (first mclk of a frame)
//     frame_last   out  count is FRAME_LEN-1 (last mclk of a frame)
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int MCLK_DIV  = I2S_MCLK_DIV,
  localparam int FRAME_LEN = frame_len(SLOT_BITS, MCLK_DIV),
  localparam int CNT_W     = $clog2(FRAME_LEN),
  localparam int DIV_W     = $clog2(MCLK_DIV),
  localparam int SLOT_W    = $clog2(SLOT_BITS)
) (
  input  logic              mclk,
  input  logic              rst,
  output logic              bclk_phase,
  output logic [SLOT_W-1:0] slot_bit,
  output logic              channel,
  output logic              frame_first,
  output logic              frame_last
);

  logic [CNT_W-1:0] cnt;

  // The frame length is a power of two, so the counter wraps from
  // FRAME_LEN-1 back to 0 simply by overflowing.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The count is laid out as {channel, slot_bit, bclk_phase, sub-phase}:
  // the top bit of the divider field is a 50% duty bit clock, the next
  // field counts bit clocks within a slot, and the MSB picks the channel.
  assign bclk_phase  = cnt[DIV_W-1];
  assign slot_bit    = cnt[DIV_W +: SLOT_W];
  assign channel     = cnt[CNT_W-1];
  assign frame_first = (cnt == '0);
  assign frame_last  = (cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Accepts stereo sample pairs over valid/ready, holds one pair in a
//   buffer, and shifts the current frame out as Philips I2S.
//   Ports:
//     mclk          in   master clock (256 x Fs at defaults)
//     rst           in   synchronous active-high reset
//     s_sample_l    in   left sample
//     s_sample_r    in   right sample
//     s_valid       in   sample pair offered
//     s_ready       out  pair can be taken this cycle
//     i2s_bclk      out  bit clock
//     i2s_lrclk     out  word select, 0 = left, 1 = right
//     i2s_sdata     out  serial data, MSB first
//     frame_start   out  one-cycle pulse as a new frame starts on the wire
//     underrun      out  one-cycle pulse when a frame started without new data
//     underrun_cnt  out  saturating count of underrun pulses
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = I2S_SLOT_BITS,
  parameter int MCLK_DIV    = I2S_MCLK_DIV
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] s_sample_l,
  input  logic [SAMPLE_BITS-1:0] s_sample_r,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   i2s_bclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_sdata,
  output logic                   frame_start,
  output logic                   underrun,
  output logic [15:0]            underrun_cnt
);

  localparam int SLOT_W = $clog2(SLOT_BITS);
  localparam int IDX_W  = $clog2(SAMPLE_BITS);
  localparam logic [SLOT_W-1:0] DATA_BITS = SLOT_W'(SAMPLE_BITS);

  logic                   bclk_phase;
  logic [SLOT_W-1:0]      slot_bit;
  logic                   channel;
  logic                   frame_first;
  logic                   frame_last;

  logic                   full;
  logic [SAMPLE_BITS-1:0] buf_l;
  logic [SAMPLE_BITS-1:0] buf_r;
  logic [SAMPLE_BITS-1:0] frame_l;
  logic [SAMPLE_BITS-1:0] frame_r;
  logic                   load_missed;
  logic                   accept;
  logic [SAMPLE_BITS-1:0] word;
  logic [IDX_W-1:0]       bit_idx;
  logic                   bit_sel;
  logic                   underrun_next;

  i2s_clkgen #(
    .SLOT_BITS (SLOT_BITS),
    .MCLK_DIV  (MCLK_DIV)
  ) u_clkgen (
    .mclk        (mclk),
    .rst         (rst),
    .bclk_phase  (bclk_phase),
    .slot_bit    (slot_bit),
    .channel     (channel),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  // The last mclk of a frame drains the buffer into the frame registers,
  // so a full buffer can take a new pair on exactly that cycle.
  assign s_ready = !full || frame_last;
  assign accept  = s_valid && s_ready;

  // Holding buffer. A new pair always lands here (never straight into the
  // frame registers); a frame load empties it unless it was refilled on
  // the same cycle.
  always_ff @(posedge mclk) begin
    if (rst) begin
      full  <= 1'b0;
      buf_l <= '0;
      buf_r <= '0;
    end else if (accept) begin
      full  <= 1'b1;
      buf_l <= s_sample_l;
      buf_r <= s_sample_r;
    end else if (frame_last) begin
      full <= 1'b0;
    end
  end

  // Frame registers load from the buffer at the frame boundary. With an
  // empty buffer they keep the previous pair so the codec repeats the
  // last sample, and the miss is remembered until the frame goes out.
  always_ff @(posedge mclk) begin
    if (rst) begin
      frame_l     <= '0;
      frame_r     <= '0;
      load_missed <= 1'b0;
    end else if (frame_last) begin
      if (full) begin
        frame_l <= buf_l;
        frame_r <= buf_r;
      end
      load_missed <= !full;
    end
  end

  // Slot bit 0 is the one-BCLK I2S delay after the LRCLK edge, bits
  // 1..SAMPLE_BITS carry the sample MSB first, the rest of the slot pads
  // with zeros.
  always_comb begin
    word    = channel ? frame_r : frame_l;
    bit_idx = IDX_W'(DATA_BITS - slot_bit);
    bit_sel = 1'b0;
    if ((slot_bit != '0) && (slot_bit <= DATA_BITS)) begin
      bit_sel = word[bit_idx];
    end
  end

  assign underrun_next = frame_first && load_missed;

  // All wire-side outputs are registered together so bclk, lrclk and
  // sdata stay aligned; data therefore changes as bclk falls.
  always_ff @(posedge mclk) begin
    if (rst) begin
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      i2s_bclk    <= bclk_phase;
      i2s_lrclk   <= channel;
      i2s_sdata   <= bit_sel;
      frame_start <= frame_first;
      underrun    <= underrun_next;
    end
  end

  // Underrun counter sticks at all-ones rather than wrapping, so a long
  // starvation is never reported as a small number.
  always_ff @(posedge mclk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun_next && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer
//   Directed bench for i2s_tx_serializer. Stimulus pushes the frame it
//   expects onto a queue; an independent monitor decodes the I2S wire,
//   and on every frame_start pops the expected frame and compares.
module tb_i2s_tx_serializer;

  logic        mclk;
  logic        rst;
  logic [15:0] s_sample_l;
  logic [15:0] s_sample_r;
  logic        s_valid;
  logic        s_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_start;
  logic        underrun;
  logic [15:0] underrun_cnt;

  typedef struct {
    int          id;
    logic [15:0] l;
    logic [15:0] r;
    logic        und;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   tb_cyc = 0;

  i2s_tx_serializer dut (
    .mclk         (mclk),
    .rst          (rst),
    .s_sample_l   (s_sample_l),
    .s_sample_r   (s_sample_r),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Bench copy of the frame position: at a falling edge it equals the
  // count the DUT will act on at the next rising edge.
  always @(posedge mclk) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int id, input logic [15:0] l, input logic [15:0] r, input logic und);
    exp_t e;
    e.id = id; e.l = l; e.r = r; e.und = und;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (tb_cyc != target && guard < 5000) begin
      @(negedge mclk);
      guard++;
    end
    if (tb_cyc != target) chk($sformatf("wait_cyc_%0d", target), tb_cyc, target);
  endtask

  // Offer a pair; junk is driven while the block is not ready so a stalled
  // offer must leave no trace. Returns the frame position of the accept.
  task automatic offer(input logic [15:0] l, input logic [15:0] r, input bit drop, output int acc);
    int guard = 0;
    s_valid = 1'b1;
    while (!s_ready && guard < 1000) begin
      s_sample_l = ~l;
      s_sample_r = ~r;
      @(negedge mclk);
      guard++;
    end
    s_sample_l = l;
    s_sample_r = r;
    acc = s_ready ? tb_cyc : -1;
    @(negedge mclk);
    if (drop) begin
      s_valid    = 1'b0;
      s_sample_l = 16'h0000;
      s_sample_r = 16'h0000;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_wire"}, {27'd0, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun}, 32'd0);
    chk({name, "_ready"}, {31'd0, s_ready}, 32'd1);
    chk({name, "_ucnt"}, {16'd0, underrun_cnt}, 32'd0);
  endtask

  // ---------------- monitor ----------------
  int          frame_id;
  bit          in_frame;
  int          rises, len, mcyc, last_rise;
  bit          have_rise, prev_bclk, last_bit;
  bit          zeros_bad, lr_bad, period_bad, stable_bad, stray_und, und_seen;
  logic [15:0] lbits, rbits;

  task automatic complete_frame();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk($sformatf("unexpected_frame_%0d", frame_id), 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("f%0d_id", e.id), frame_id, e.id);
      chk($sformatf("f%0d_left", e.id), {16'd0, lbits}, {16'd0, e.l});
      chk($sformatf("f%0d_right", e.id), {16'd0, rbits}, {16'd0, e.r});
      chk($sformatf("f%0d_underrun", e.id), {31'd0, und_seen}, {31'd0, e.und});
      chk($sformatf("f%0d_stray_underrun", e.id), {31'd0, stray_und}, 32'd0);
      chk($sformatf("f%0d_pad_zeros", e.id), {31'd0, zeros_bad}, 32'd0);
      chk($sformatf("f%0d_lrclk", e.id), {31'd0, lr_bad}, 32'd0);
      chk($sformatf("f%0d_bclk_period", e.id), {31'd0, period_bad}, 32'd0);
      chk($sformatf("f%0d_sdata_stable", e.id), {31'd0, stable_bad}, 32'd0);
      chk($sformatf("f%0d_bclk_count", e.id), rises, 64);
      chk($sformatf("f%0d_length", e.id), len, 256);
    end
  endtask

  initial begin
    int b;
    bit ch;
    frame_id = -1; in_frame = 0; have_rise = 0; prev_bclk = 0; mcyc = 0;
    forever begin
      @(negedge mclk);
      mcyc++;
      if (rst) begin
        in_frame  = 0;
        frame_id  = -1;
        have_rise = 0;
        prev_bclk = 0;
      end else begin
        if (frame_start) begin
          if (in_frame) complete_frame();
          in_frame = 1; frame_id++;
          rises = 0; len = 0; lbits = '0; rbits = '0;
          zeros_bad = 0; lr_bad = 0; period_bad = 0; stable_bad = 0; stray_und = 0;
          und_seen = underrun;
        end else if (underrun) begin
          stray_und = 1;
        end
        if (in_frame) len++;
        if (i2s_bclk && !prev_bclk) begin
          if (have_rise && (mcyc - last_rise != 4)) period_bad = 1;
          have_rise = 1;
          last_rise = mcyc;
          last_bit  = i2s_sdata;
          if (in_frame) begin
            b  = rises % 32;
            ch = (rises >= 32);
            if (i2s_lrclk != ch) lr_bad = 1;
            if (b >= 1 && b <= 16) begin
              if (ch) rbits[16-b] = i2s_sdata;
              else    lbits[16-b] = i2s_sdata;
            end else if (i2s_sdata) begin
              zeros_bad = 1;
            end
            rises++;
          end
        end else if (i2s_bclk && prev_bclk && (i2s_sdata != last_bit)) begin
          stable_bad = 1;
        end
        prev_bclk = i2s_bclk;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    rst = 1'b1; s_valid = 1'b0; s_sample_l = '0; s_sample_r = '0;
    repeat (3) @(negedge mclk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Idle from reset: zero frames, underrun from the second frame on.
    expect_frame(0, 16'h0000, 16'h0000, 1'b0);
    expect_frame(1, 16'h0000, 16'h0000, 1'b1);
    expect_frame(2, 16'h0000, 16'h0000, 1'b1);
    expect_frame(3, 16'h0000, 16'h0000, 1'b1);
    wait_cyc(773);
    chk("ucnt_idle", {16'd0, underrun_cnt}, 32'd3);

    // Single early pair, then repeated once starved.
    expect_frame(4, 16'h8001, 16'h7FFE, 1'b0);
    expect_frame(5, 16'h8001, 16'h7FFE, 1'b1);
    wait_cyc(778);
    offer(16'h8001, 16'h7FFE, 1'b1, acc);
    chk("acc_single", acc, 778);

    // Source always valid: one accept per frame, only at the last count.
    expect_frame(6, 16'h0F0F, 16'hF0F0, 1'b0);
    expect_frame(7, 16'h1357, 16'h2468, 1'b0);
    expect_frame(8, 16'hFFFF, 16'h0001, 1'b0);
    expect_frame(9, 16'h8000, 16'h7FFF, 1'b0);
    expect_frame(10, 16'h8000, 16'h7FFF, 1'b1);
    wait_cyc(1290);
    chk("ucnt_before_stream", {16'd0, underrun_cnt}, 32'd4);
    offer(16'h0F0F, 16'hF0F0, 1'b0, acc);
    chk("acc_p0", acc, 1290);
    offer(16'h1357, 16'h2468, 1'b0, acc);
    chk("acc_p1", acc, 1535);
    offer(16'hFFFF, 16'h0001, 1'b0, acc);
    chk("acc_p2", acc, 1791);
    offer(16'h8000, 16'h7FFF, 1'b1, acc);
    chk("acc_p3", acc, 2047);

    // Pair offered on the last count with an empty buffer.
    expect_frame(11, 16'h8000, 16'h7FFF, 1'b1);
    expect_frame(12, 16'hA5A5, 16'h5A5A, 1'b0);
    wait_cyc(2815);
    offer(16'hA5A5, 16'h5A5A, 1'b1, acc);
    chk("acc_last_cnt", acc, 2815);
    chk("ready_after_fill", {31'd0, s_ready}, 32'd0);
    wait_cyc(3082);
    chk("ucnt_after_late", {16'd0, underrun_cnt}, 32'd6);

    // Fill the buffer, then reset mid-frame.
    wait_cyc(3400);
    offer(16'hDEAD, 16'hBEEF, 1'b1, acc);
    chk("acc_before_rst", acc, 3400);
    wait_cyc(3427);
    chk("ready_full", {31'd0, s_ready}, 32'd0);
    @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    check_reset_outputs("midrst");
    @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    chk("restart_frame_start", {30'd0, frame_start, i2s_lrclk}, 32'd2);

    // Starvation after one pair, then saturation of the counter.
    expect_frame(0, 16'h0000, 16'h0000, 1'b0);
    expect_frame(1, 16'h1234, 16'h5678, 1'b0);
    expect_frame(2, 16'h1234, 16'h5678, 1'b1);
    expect_frame(3, 16'h1234, 16'h5678, 1'b1);
    expect_frame(4, 16'h1234, 16'h5678, 1'b1);
    wait_cyc(10);
    offer(16'h1234, 16'h5678, 1'b1, acc);
    chk("acc_after_rst", acc, 10);
    wait_cyc(778);
    chk("ucnt_starve2", {16'd0, underrun_cnt}, 32'd2);
    wait_cyc(1034);
    chk("ucnt_starve3", {16'd0, underrun_cnt}, 32'd3);
    wait_cyc(1040);
    force dut.underrun_cnt = 16'hFFFF;
    repeat (2) @(negedge mclk);
    release dut.underrun_cnt;
    wait_cyc(1050);
    chk("ucnt_forced", {16'd0, underrun_cnt}, 32'h0000FFFF);
    wait_cyc(1290);
    chk("ucnt_saturated", {16'd0, underrun_cnt}, 32'h0000FFFF);

    chk("frames_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
